// File: rtl/first_nios2_system_pkg.sv
// Shared constants and FSM encoding for the sysid read arbiter.
package first_nios2_system_pkg;

    localparam int NUM_MASTERS   = 2;
    localparam int DEFAULT_CNT_W = 16;
    localparam int DATA_W        = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/first_nios2_system_sysid_arbiter_if.sv
// Bus bundle between two Avalon-MM read masters, the arbiter and the sysid slave.
interface first_nios2_system_sysid_arbiter_if
    import first_nios2_system_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic              m0_read;
    logic              m1_read;
    logic              m0_address;
    logic              m1_address;
    logic              m0_waitrequest;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic [DATA_W-1:0] m1_readdata;
    logic              m0_readdatavalid;
    logic              m1_readdatavalid;
    logic              s_address;
    logic [DATA_W-1:0] s_readdata;
    logic [CNT_W-1:0]  m0_grant_cnt;
    logic [CNT_W-1:0]  m1_grant_cnt;
    logic              busy;

    // Arbiter side: sees master requests and slave data, drives everything else.
    modport slave (
        input  m0_read, m1_read, m0_address, m1_address, s_readdata,
        output m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
        output m0_readdatavalid, m1_readdatavalid, s_address,
        output m0_grant_cnt, m1_grant_cnt, busy
    );

    modport master (
        output m0_read, m1_read, m0_address, m1_address, s_readdata,
        input  m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
        input  m0_readdatavalid, m1_readdatavalid, s_address,
        input  m0_grant_cnt, m1_grant_cnt, busy
    );

endinterface

// File: rtl/first_nios2_system_rr_pick.sv
// Combinational 2-way round-robin picker: a sole requester wins, a tie goes
// to the master that was not granted last.
module first_nios2_system_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/first_nios2_system_sysid_arbiter.sv
// Two-master round-robin arbiter in front of the combinational sysid slave.
// Each read takes GRANT (accept + capture) then RESP (valid strobe).
module first_nios2_system_sysid_arbiter
    import first_nios2_system_pkg::*;
#(
    parameter int NUM_MASTERS = first_nios2_system_pkg::NUM_MASTERS,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input logic clock,
    input logic reset,
    first_nios2_system_sysid_arbiter_if.slave bus
);

    arb_state_t              state;
    logic                    grant_id;
    logic                    last_grant;
    logic                    s_addr_q;
    logic                    busy_q;
    logic [NUM_MASTERS-1:0]  waitreq_q;
    logic [NUM_MASTERS-1:0]  rdvalid_q;
    logic [DATA_W-1:0]       rdata_q [NUM_MASTERS];
    logic [CNT_W-1:0]        cnt_q   [NUM_MASTERS];

    logic [NUM_MASTERS-1:0]  req;
    logic [NUM_MASTERS-1:0]  addr;
    logic                    pick_winner;
    logic                    pick_valid;

    assign req  = {bus.m1_read, bus.m0_read};
    assign addr = {bus.m1_address, bus.m0_address};

    first_nios2_system_rr_pick u_pick (
        .req    (req),
        .last   (last_grant),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Arbitration happens in IDLE and RESP alike, so back-to-back reads
    // cost two cycles each; all outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            s_addr_q   <= 1'b0;
            busy_q     <= 1'b0;
            waitreq_q  <= '1;
            rdvalid_q  <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                rdata_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    rdvalid_q <= '0;
                    if (pick_valid) begin
                        state     <= GRANT;
                        grant_id  <= pick_winner;
                        s_addr_q  <= addr[pick_winner];
                        waitreq_q <= ~(NUM_MASTERS'(1) << pick_winner);
                        busy_q    <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        s_addr_q  <= 1'b0;
                        waitreq_q <= '1;
                        busy_q    <= 1'b0;
                    end
                end
                GRANT: begin
                    rdata_q[grant_id] <= bus.s_readdata;
                    cnt_q[grant_id]   <= cnt_q[grant_id] + CNT_W'(1);
                    last_grant        <= grant_id;
                    rdvalid_q         <= NUM_MASTERS'(1) << grant_id;
                    waitreq_q         <= '1;
                    s_addr_q          <= 1'b0;
                    busy_q            <= 1'b1;
                    state             <= RESP;
                end
                default: begin
                    state     <= IDLE;
                    rdvalid_q <= '0;
                    waitreq_q <= '1;
                    s_addr_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m0_waitrequest   = waitreq_q[0];
    assign bus.m1_waitrequest   = waitreq_q[1];
    assign bus.m0_readdatavalid = rdvalid_q[0];
    assign bus.m1_readdatavalid = rdvalid_q[1];
    assign bus.m0_readdata      = rdata_q[0];
    assign bus.m1_readdata      = rdata_q[1];
    assign bus.m0_grant_cnt     = cnt_q[0];
    assign bus.m1_grant_cnt     = cnt_q[1];
    assign bus.s_address        = s_addr_q;
    assign bus.busy             = busy_q;

endmodule

// File: doc/first_nios2_system_sysid_arbiter.md
FIRST_NIOS2_SYSTEM_SYSID_ARBITER -- requirements
Module: first_nios2_system_sysid_arbiter

Interface
REQ-001 SHALL have parameter: NUM_MASTERS, 2, number of Avalon-MM read masters (only 2 supported).
REQ-002 SHALL have parameter: CNT_W, 16, width of per-master grant counters.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clock  in  1  rising-edge clock for all state.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: m0_read / m1_read  in  1  master read request, held until accepted.
REQ-007 SHALL have ports: m0_address / m1_address  in  1  master word address.
REQ-008 SHALL have ports: m0_waitrequest / m1_waitrequest  out  1  high = request not yet accepted.
REQ-009 SHALL have ports: m0_readdata / m1_readdata  out  32  registered response data.
REQ-010 SHALL have ports: m0_readdatavalid / m1_readdatavalid  out  1  one-cycle response strobe.
REQ-011 SHALL have port: s_address  out  1  address to the sysid slave.
REQ-012 SHALL have port: s_readdata  in  32  combinational sysid slave data.
REQ-013 SHALL have ports: m0_grant_cnt / m1_grant_cnt  out  CNT_W  accepted-read count per master.
REQ-014 SHALL have port: busy  out  1  high when state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, RESP.
REQ-016 SHALL leave IDLE for GRANT when any mN_read is high, latching the winner in grant_id.
REQ-017 SHALL pick the winner round-robin: a sole requester wins; if both request, the master not equal to last_grant wins.
REQ-018 SHALL, in GRANT, drive s_address = winner's address and deassert only the winner's waitrequest (acceptance cycle).
REQ-019 SHALL, in GRANT, register s_readdata into the winner's readdata and update last_grant = winner.
REQ-020 SHALL, in RESP, pulse the winner's readdatavalid for exactly one cycle, with readdata stable that cycle.
REQ-021 SHALL go RESP->GRANT directly when any request is pending (re-arbitrated with the updated last_grant), else RESP->IDLE.
REQ-022 SHALL give read latency of 2 cycles from first sampled read in IDLE to readdatavalid; sustained throughput is one read per 2 cycles.
REQ-023 SHALL hold waitrequest high for every master outside its own acceptance cycle, including while its read is low.
REQ-024 SHALL drive s_address = 0 in IDLE and RESP.
REQ-025 SHALL retain readdata between responses; the non-granted master's readdata SHALL NOT change.
REQ-026 SHALL increment mN_grant_cnt by 1 at each acceptance of master N, wrapping modulo 2^CNT_W.
REQ-027 SHALL ignore a master that drops read before acceptance: no grant, no count, no response.
REQ-028 SHALL never assert both readdatavalid outputs in the same cycle.

Reset
REQ-029 SHALL, on reset, set state=IDLE, last_grant=1 (so m0 wins the first tie), readdata=0, readdatavalid=0, counters=0, busy=0, waitrequest=1 for both masters.
REQ-030 SHALL, on reset mid-transaction, abort with no readdatavalid issued and no counter update for the aborted read.

Structure
REQ-031 SHALL place the FSM state encodings, NUM_MASTERS and the default CNT_W in a shared package/include (first_nios2_system_pkg).
REQ-032 SHALL use one sub-module, first_nios2_system_rr_pick (combinational 2-way round-robin picker: req[1:0], last -> winner, valid).

Verification (s_readdata model: address 1 -> 1362754112, address 0 -> 0)
REQ-033 SHALL cover: m0 read, addr=1, from IDLE -> m0_waitrequest low on cycle 1, m0_readdatavalid on cycle 2 with m0_readdata=1362754112, m0_grant_cnt=1.
REQ-034 SHALL cover: both read from reset, m0 addr=1, m1 addr=0 -> m0 served first (1362754112), m1 served next via RESP->GRANT (0), valids on cycles 2 and 4.
REQ-035 SHALL cover: both masters read continuously for 8 grants -> strict alternation m0,m1,..., each counter=4, never both valids high.
REQ-036 SHALL cover: reset asserted in GRANT -> no readdatavalid afterwards, counters 0, waitrequest both 1, busy 0.
REQ-037 SHALL cover: m1_grant_cnt preloaded to 0xFFFF via 65535 reads, one more m1 read -> m1_grant_cnt=0x0000.
REQ-038 SHALL cover: m1 asserts read one cycle then drops it while m0 is being served -> m1 not granted, m1_grant_cnt unchanged.
